// File: rtl/sr_latch_pkg.sv
// Shared encodings and next-state rule for the clocked SR storage bits.
package sr_latch_pkg;

  localparam int SR_HOLD    = 0;
  localparam int SR_SET_DOM = 1;
  localparam int SR_RST_DOM = 2;
  localparam int SR_TOGGLE  = 3;

  function automatic logic sr_next(input logic q, input logic s, input logic r, input int mode);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      2'b11: begin
        case (mode)
          SR_SET_DOM: nxt = 1'b1;
          SR_RST_DOM: nxt = 1'b0;
          SR_TOGGLE:  nxt = ~q;
          default:    nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_latch_cell.sv
// One SR storage bit: single flop with async reset, Qb derived combinationally.
// Optional S=R=1 debug flag when SR_LATCH_BOTH_FLAG_EN is defined.
module sr_cell
  import sr_latch_pkg::*;
#(
  parameter int BOTH_MODE = SR_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
`ifdef SR_LATCH_BOTH_FLAG_EN
  output logic both,
`endif
  output logic qb
);

  logic q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= 1'b0;
    end else begin
      q_reg <= sr_next(q_reg, s, r, BOTH_MODE);
    end
  end

  // Qb comes from the same flop so Q and Qb can never agree.
  assign q  = q_reg;
  assign qb = ~q_reg;

`ifdef SR_LATCH_BOTH_FLAG_EN
  logic both_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      both_reg <= 1'b0;
    end else begin
      both_reg <= s & r;
    end
  end

  assign both = both_reg;
`endif

endmodule

// File: rtl/sr_latch.sv
// WIDTH independent edge-triggered SR bits with complementary outputs.
// Defining SR_LATCH_BOTH_FLAG_EN adds the registered `both` debug output.
module sr_latch
  import sr_latch_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int BOTH_MODE = SR_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
`ifdef SR_LATCH_BOTH_FLAG_EN
  output logic [WIDTH-1:0] both,
`endif
  output logic [WIDTH-1:0] Qb
);

  if (BOTH_MODE < SR_HOLD || BOTH_MODE > SR_TOGGLE) begin : g_bad_mode
    $error("sr_latch: BOTH_MODE must be 0..3");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_cell #(
      .BOTH_MODE(BOTH_MODE)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .s   (S[i]),
      .r   (R[i]),
      .q   (Q[i]),
`ifdef SR_LATCH_BOTH_FLAG_EN
      .both(both[i]),
`endif
      .qb  (Qb[i])
    );
  end

endmodule

// File: tb/tb_sr_latch.sv
// Self-checking bench: four WIDTH=4 instances, one per BOTH_MODE, against a vector-level model.
module tb_sr_latch;

  logic       clk;
  logic       rst;
  logic [3:0] S;
  logic [3:0] R;
  logic [3:0] q_arr  [4];
  logic [3:0] qb_arr [4];
  logic [3:0] both_arr [4];
  logic [3:0] mq [4];
  logic [3:0] mb;
  int vectors;
  int miscompares;

  for (genvar m = 0; m < 4; m++) begin : g_dut
`ifdef SR_LATCH_BOTH_FLAG_EN
    sr_latch #(.WIDTH(4), .BOTH_MODE(m)) dut (
      .clk(clk), .rst(rst), .S(S), .R(R), .Q(q_arr[m]), .both(both_arr[m]), .Qb(qb_arr[m])
    );
`else
    sr_latch #(.WIDTH(4), .BOTH_MODE(m)) dut (
      .clk(clk), .rst(rst), .S(S), .R(R), .Q(q_arr[m]), .Qb(qb_arr[m])
    );
    assign both_arr[m] = 4'h0;
`endif
  end

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("%s.q.m%0d", tag, m), q_arr[m], mq[m]);
      check($sformatf("%s.qb.m%0d", tag, m), qb_arr[m], ~mq[m]);
`ifdef SR_LATCH_BOTH_FLAG_EN
      check($sformatf("%s.both.m%0d", tag, m), both_arr[m], mb);
`endif
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 4; m++) mq[m] = 4'h0;
    mb = 4'h0;
  endtask

  // Reference rule: hold, set, clear, or the mode's S=R=1 action per bit.
  task automatic model_edge();
    logic [3:0] both_val;
    for (int m = 0; m < 4; m++) begin
      case (m)
        0: both_val = mq[m];
        1: both_val = 4'hF;
        2: both_val = 4'h0;
        default: both_val = ~mq[m];
      endcase
      mq[m] = (mq[m] & ~S & ~R) | (S & ~R) | (S & R & both_val);
    end
    mb = S & R;
  endtask

  task automatic drive(input logic [3:0] s_val, input logic [3:0] r_val);
    @(negedge clk);
    S = s_val;
    R = r_val;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    S = 4'h0;
    R = 4'h0;
    #10;
    rst = 1'b1;
    model_reset();

    // Reset dominates a pending set while the clock runs.
    S = 4'hF;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all("reset_hold");
    end
    @(negedge clk);
    rst = 1'b0;
    tick("reset_release");
    check("release_q1", q_arr[0], 4'hF);

    // Basic sequence from a cleared state.
    drive(4'h0, 4'hF); tick("clear");
    drive(4'hF, 4'h0); tick("basic_set");
    check("basic_set_lit", q_arr[0], 4'hF);
    drive(4'h0, 4'hF); tick("basic_rst");
    check("basic_rst_lit", q_arr[0], 4'h0);
    drive(4'h0, 4'h0); tick("basic_hold");
    drive(4'hF, 4'hF); tick("basic_both");
    check("both_hold_lit", q_arr[0], 4'h0);
    check("both_set_lit", q_arr[1], 4'hF);
    check("both_rst_lit", q_arr[2], 4'h0);
    check("toggle1_lit", q_arr[3], 4'hF);
    tick("toggle2");
    check("toggle2_lit", q_arr[3], 4'h0);
    tick("toggle3");
    check("toggle3_lit", q_arr[3], 4'hF);

    // Async reset pulse between edges.
    drive(4'hF, 4'h0); tick("pre_async");
    @(negedge clk);
    S = 4'h0;
    R = 4'h0;
    #10 rst = 1'b1;
    model_reset();
    #5;
    check_all("async_rst");
    check("async_rst_lit", q_arr[1], 4'h0);
    #5 rst = 1'b0;
    tick("post_async");

    // Short S glitch away from the edge must not be captured.
    @(negedge clk);
    #20 S = 4'hF;
    #10 S = 4'h0;
    tick("glitch");
    check("glitch_lit", q_arr[0], 4'h0);

    // Mixed per-bit requests.
    drive(4'b1010, 4'b0101); tick("mixed");
    check("mixed_q_lit", q_arr[0], 4'b1010);
    check("mixed_qb_lit", qb_arr[0], 4'b0101);
    drive(4'b0011, 4'b0011); tick("flag_on");
`ifdef SR_LATCH_BOTH_FLAG_EN
    check("flag_on_lit", both_arr[0], 4'b0011);
`endif
    drive(4'h0, 4'h0); tick("flag_off");
`ifdef SR_LATCH_BOTH_FLAG_EN
    check("flag_off_lit", both_arr[0], 4'b0000);
`endif

    // Randomised run with occasional mid-cycle resets.
    for (int n = 0; n < 300; n++) begin
      drive(4'($urandom), 4'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        #10 rst = 1'b1;
        model_reset();
        #5;
        check_all("rand_rst");
        #5 rst = 1'b0;
      end
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
